// File: rtl/rv_dmem_port.sv
// rtl/rv_dmem_port.sv - data-memory access unit between execute and the data bus
module rv_dmem_port #(
    parameter int unsigned g_timeout = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        x_load_i,
    input  logic        x_store_i,
    input  logic [2:0]  x_fun_i,
    input  logic [31:0] x_dm_addr_i,
    input  logic [31:0] x_store_value_i,
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_data_s_o,
    output logic [3:0]  dm_data_select_o,
    output logic        dm_load_o,
    output logic        dm_store_o,
    input  logic        dm_ready_i,
    input  logic [31:0] dm_data_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic        dm_misaligned_o,
    output logic        dm_timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_STORE = 2'd2
    } state_t;

    localparam logic [15:0] c_timeout = 16'(g_timeout);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_data_s;
    logic [3:0]  r_sel;
    logic [31:0] r_data_l;
    logic        r_misal;
    logic        r_misal_load;

    logic        w_is_b;
    logic        w_is_h;
    logic        w_misal;
    logic [3:0]  w_sel;
    logic [31:0] w_data_s;
    logic        w_req;
    logic        w_expired;
    logic        w_finish;
    logic        w_load;
    logic        w_store;
    logic        w_ld_done;
    logic        w_st_done;
    logic        w_tmo;
    logic [31:0] w_data_l;

    // Decode access size; unsigned variants share lanes with their signed forms,
    // and every unlisted encoding behaves as a full word.
    always_comb begin
        w_is_b = 1'b0;
        w_is_h = 1'b0;
        case (x_fun_i)
            3'b000, 3'b100: w_is_b = 1'b1;
            3'b001, 3'b101: w_is_h = 1'b1;
            default: ;
        endcase
    end

    // Alignment check, byte enables and lane-replicated store data for the request.
    always_comb begin
        w_misal  = 1'b0;
        w_sel    = 4'b1111;
        w_data_s = x_store_value_i;
        if (w_is_b) begin
            w_sel    = 4'b0001 << x_dm_addr_i[1:0];
            w_data_s = {4{x_store_value_i[7:0]}};
        end else if (w_is_h) begin
            w_misal  = x_dm_addr_i[0];
            w_sel    = x_dm_addr_i[1] ? 4'b1100 : 4'b0011;
            w_data_s = {2{x_store_value_i[15:0]}};
        end else begin
            w_misal  = (x_dm_addr_i[1:0] != 2'b00);
        end
    end

    assign w_req     = x_load_i | x_store_i;
    assign w_expired = (r_cnt == c_timeout);
    assign w_finish  = (r_state != ST_IDLE) && (dm_ready_i || w_expired);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, bus strobes and completion strobes; ready wins over expiry.
    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_store   = 1'b0;
        w_ld_done = r_misal & r_misal_load;
        w_st_done = r_misal & ~r_misal_load;
        w_tmo     = 1'b0;
        w_data_l  = r_data_l;
        case (r_state)
            ST_IDLE: begin
                if (x_load_i) begin
                    if (!w_misal) w_next = ST_LOAD;
                end else if (x_store_i) begin
                    if (!w_misal) w_next = ST_STORE;
                end
            end
            ST_LOAD: begin
                w_load = 1'b1;
                if (dm_ready_i) begin
                    w_ld_done = 1'b1;
                    w_data_l  = dm_data_i;
                    w_next    = ST_IDLE;
                end else if (w_expired) begin
                    w_ld_done = 1'b1;
                    w_tmo     = 1'b1;
                    w_data_l  = 32'h0;
                    w_next    = ST_IDLE;
                end
            end
            ST_STORE: begin
                w_store = 1'b1;
                if (dm_ready_i) begin
                    w_st_done = 1'b1;
                    w_next    = ST_IDLE;
                end else if (w_expired) begin
                    w_st_done = 1'b1;
                    w_tmo     = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Request capture, wait counter, misalignment pulse and load-word holding register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt        <= 16'd0;
            r_addr       <= 32'h0;
            r_data_s     <= 32'h0;
            r_sel        <= 4'b0000;
            r_data_l     <= 32'h0;
            r_misal      <= 1'b0;
            r_misal_load <= 1'b0;
        end else begin
            r_misal <= 1'b0;
            if (r_state == ST_IDLE) begin
                r_cnt <= 16'd0;
                if (w_req) begin
                    if (w_misal) begin
                        r_misal      <= 1'b1;
                        r_misal_load <= x_load_i;
                        r_data_l     <= 32'h0;
                    end else begin
                        r_addr   <= {x_dm_addr_i[31:2], 2'b00};
                        r_sel    <= w_sel;
                        r_data_s <= w_data_s;
                    end
                end
            end else begin
                r_cnt <= r_cnt + 16'd1;
                if (w_finish) begin
                    r_sel <= 4'b0000;
                    if (r_state == ST_LOAD) r_data_l <= w_data_l;
                end
            end
        end
    end

    assign dm_addr_o        = r_addr;
    assign dm_data_s_o      = r_data_s;
    assign dm_data_select_o = r_sel;
    assign dm_load_o        = w_load;
    assign dm_store_o       = w_store;
    assign dm_data_l_o      = w_data_l;
    assign dm_load_done_o   = w_ld_done;
    assign dm_store_done_o  = w_st_done;
    assign dm_misaligned_o  = r_misal;
    assign dm_timeout_o     = w_tmo;

endmodule

// File: tb/tb_rv_dmem_port.sv
// tb/tb_rv_dmem_port.sv - self-checking bench for rv_dmem_port
module tb_rv_dmem_port;

    localparam int TMO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        x_load_i;
    logic        x_store_i;
    logic [2:0]  x_fun_i;
    logic [31:0] x_dm_addr_i;
    logic [31:0] x_store_value_i;
    logic [31:0] dm_addr_o;
    logic [31:0] dm_data_s_o;
    logic [3:0]  dm_data_select_o;
    logic        dm_load_o;
    logic        dm_store_o;
    logic        dm_ready_i;
    logic [31:0] dm_data_i;
    logic [31:0] dm_data_l_o;
    logic        dm_load_done_o;
    logic        dm_store_done_o;
    logic        dm_misaligned_o;
    logic        dm_timeout_o;

    rv_dmem_port #(.g_timeout(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .x_load_i(x_load_i), .x_store_i(x_store_i), .x_fun_i(x_fun_i),
        .x_dm_addr_i(x_dm_addr_i), .x_store_value_i(x_store_value_i),
        .dm_addr_o(dm_addr_o), .dm_data_s_o(dm_data_s_o),
        .dm_data_select_o(dm_data_select_o), .dm_load_o(dm_load_o),
        .dm_store_o(dm_store_o), .dm_ready_i(dm_ready_i), .dm_data_i(dm_data_i),
        .dm_data_l_o(dm_data_l_o), .dm_load_done_o(dm_load_done_o),
        .dm_store_done_o(dm_store_done_o), .dm_misaligned_o(dm_misaligned_o),
        .dm_timeout_o(dm_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;
    logic [31:0] held = 32'h0;

    typedef struct {
        string       nm;
        logic [2:0]  fun;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        bit          ld;
        int          delay;
        logic [3:0]  esel;
        logic [31:0] eds;
        bit          emis;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int m_size(input logic [2:0] fun);
        if (fun[1:0] == 2'b00) return 1;
        if (fun[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit m_misal(input logic [2:0] fun, input logic [31:0] addr);
        return (addr % m_size(fun)) != 0;
    endfunction

    function automatic logic [3:0] m_sel(input logic [2:0] fun, input logic [31:0] addr);
        int sz = m_size(fun);
        int sh = int'(addr % 4);
        logic [3:0] mask = 4'((1 << sz) - 1);
        if (sz == 4) return 4'hF;
        return 4'(mask << sh);
    endfunction

    function automatic logic [31:0] m_ds(input logic [2:0] fun, input logic [31:0] d);
        int sz = m_size(fun);
        if (sz == 1) return (d & 32'hFF) * 32'h01010101;
        if (sz == 2) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    task automatic do_access(input string nm, input logic [2:0] fun, input logic [31:0] addr,
                             input logic [31:0] sdata, input logic [31:0] rdata,
                             input bit ld, input bit st, input int delay,
                             input logic [3:0] esel, input logic [31:0] eds, input bit emis,
                             input bit busy_pulse);
        bit fin;
        bit tmo;
        bit done_seen;
        x_fun_i = fun; x_dm_addr_i = addr; x_store_value_i = sdata;
        x_load_i = ld; x_store_i = st; dm_ready_i = 1'b0;
        #1;
        chk({nm, "_idle_strobes"}, {30'd0, dm_load_o, dm_store_o}, 32'd0);
        tick();
        x_load_i = 1'b0; x_store_i = 1'b0;
        if (emis) begin
            #1;
            chk({nm, "_mis"}, {31'd0, dm_misaligned_o}, 32'd1);
            chk({nm, "_mis_done"}, {30'd0, dm_load_done_o, dm_store_done_o}, ld ? 32'd2 : 32'd1);
            chk({nm, "_mis_nobus"}, {30'd0, dm_load_o, dm_store_o}, 32'd0);
            chk({nm, "_mis_data"}, dm_data_l_o, 32'h0);
            held = 32'h0;
            tick();
            chk({nm, "_mis_after"}, {29'd0, dm_misaligned_o, dm_load_done_o, dm_store_done_o}, 32'd0);
            return;
        end
        done_seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            dm_ready_i = (k == delay);
            dm_data_i  = (k == delay) ? rdata : $urandom;
            if (busy_pulse) begin
                x_load_i  = k[0];
                x_store_i = ~k[0];
            end
            #1;
            chk({nm, "_strobe"}, {30'd0, dm_load_o, dm_store_o}, ld ? 32'd2 : 32'd1);
            chk({nm, "_addr"}, dm_addr_o, addr - (addr % 4));
            chk({nm, "_sel"}, {28'd0, dm_data_select_o}, {28'd0, esel});
            chk({nm, "_ds"}, dm_data_s_o, eds);
            fin = (k == delay) || (k == TMO);
            tmo = (k == TMO) && (delay > TMO);
            chk({nm, "_done"}, {30'd0, dm_load_done_o, dm_store_done_o},
                fin ? (ld ? 32'd2 : 32'd1) : 32'd0);
            chk({nm, "_tmo"}, {31'd0, dm_timeout_o}, {31'd0, tmo});
            if (fin && ld) begin
                held = tmo ? 32'h0 : rdata;
                chk({nm, "_ldata"}, dm_data_l_o, held);
            end
            tick();
            if (fin) begin
                done_seen = 1'b1;
                break;
            end
        end
        if (!done_seen) chk({nm, "_no_finish"}, 32'd0, 32'd1);
        x_load_i = 1'b0; x_store_i = 1'b0;
        dm_ready_i = 1'b1; dm_data_i = $urandom;
        #1;
        chk({nm, "_after_strobes"}, {28'd0, dm_load_o, dm_store_o, dm_load_done_o, dm_store_done_o}, 32'd0);
        chk({nm, "_after_tmo"}, {31'd0, dm_timeout_o}, 32'd0);
        chk({nm, "_held"}, dm_data_l_o, held);
        dm_ready_i = 1'b0;
    endtask

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{"lb_1003",   3'b000, 32'h1003, 32'h0,        32'h80FFFFFF, 1, 0, 4'b1000, 32'h00000000, 0};
        tbl[1]  = '{"sh_2002",   3'b001, 32'h2002, 32'h0000BEEF, 32'h0,        0, 3, 4'b1100, 32'hBEEFBEEF, 0};
        tbl[2]  = '{"lw_mis",    3'b010, 32'h3001, 32'h0,        32'h0,        1, 0, 4'b0000, 32'h0,        1};
        tbl[3]  = '{"sb_0005",   3'b000, 32'h0005, 32'h12345678, 32'h0,        0, 1, 4'b0010, 32'h78787878, 0};
        tbl[4]  = '{"lhu_0100",  3'b101, 32'h0100, 32'hCAFE1234, 32'hAABBCCDD, 1, 0, 4'b0011, 32'h12341234, 0};
        tbl[5]  = '{"sw_0010",   3'b010, 32'h0010, 32'hDEADBEEF, 32'h0,        0, 2, 4'b1111, 32'hDEADBEEF, 0};
        tbl[6]  = '{"lbu_0002",  3'b100, 32'h0002, 32'h0,        32'h01020304, 1, 1, 4'b0100, 32'h0,        0};
        tbl[7]  = '{"sh_mis",    3'b001, 32'h0003, 32'h1111,     32'h0,        0, 0, 4'b0000, 32'h0,        1};
        tbl[8]  = '{"lw011_edge",3'b011, 32'h0008, 32'h11223344, 32'h99887766, 1, 4, 4'b1111, 32'h11223344, 0};
        tbl[9]  = '{"lh_mis",    3'b001, 32'h0007, 32'h0,        32'h0,        1, 0, 4'b0000, 32'h0,        1};
        tbl[10] = '{"lw_tmo",    3'b010, 32'h0004, 32'h0,        32'h00000055, 1, 9, 4'b1111, 32'h0,        0};
        tbl[11] = '{"sw111_tmo", 3'b111, 32'h000C, 32'hA5A5A5A5, 32'h0,        0, 6, 4'b1111, 32'hA5A5A5A5, 0};

        rst_i = 1'b1; x_load_i = 1'b0; x_store_i = 1'b0; x_fun_i = 3'b0;
        x_dm_addr_i = 32'h0; x_store_value_i = 32'h0; dm_ready_i = 1'b1; dm_data_i = 32'hFFFFFFFF;
        tick(); tick();
        chk("rst_strobes", {28'd0, dm_load_o, dm_store_o, dm_load_done_o, dm_store_done_o}, 32'd0);
        chk("rst_flags", {26'd0, dm_data_select_o, dm_misaligned_o, dm_timeout_o}, 32'd0);
        chk("rst_addr", dm_addr_o, 32'h0);
        chk("rst_ds", dm_data_s_o, 32'h0);
        chk("rst_dl", dm_data_l_o, 32'h0);
        rst_i = 1'b0; dm_ready_i = 1'b0;
        tick();

        for (int i = 0; i < 12; i++)
            do_access(tbl[i].nm, tbl[i].fun, tbl[i].addr, tbl[i].sdata, tbl[i].rdata,
                      tbl[i].ld, !tbl[i].ld, tbl[i].delay, tbl[i].esel, tbl[i].eds,
                      tbl[i].emis, 1'b0);

        // simultaneous load and store, then request pulses while busy
        do_access("both_req", 3'b010, 32'h0020, 32'h77777777, 32'h13572468, 1, 1, 3,
                  4'hF, 32'h77777777, 0, 1);

        // reset while waiting in LOAD
        x_fun_i = 3'b010; x_dm_addr_i = 32'h40; x_load_i = 1'b1; dm_ready_i = 1'b0;
        tick();
        x_load_i = 1'b0;
        #1;
        chk("rstmid_strobe", {31'd0, dm_load_o}, 32'd1);
        tick();
        rst_i = 1'b1;
        #1;
        chk("rstmid_nodone_w", {30'd0, dm_load_done_o, dm_store_done_o}, 32'd0);
        tick();
        rst_i = 1'b0;
        #1;
        chk("rstmid_after", {27'd0, dm_load_o, dm_store_o, dm_load_done_o, dm_store_done_o, dm_timeout_o}, 32'd0);
        chk("rstmid_dl", dm_data_l_o, 32'h0);
        held = 32'h0;
        do_access("sw_after_rst", 3'b010, 32'h10, 32'h0BADF00D, 32'h0, 0, 1, 0,
                  m_sel(3'b010, 32'h10), m_ds(3'b010, 32'h0BADF00D), m_misal(3'b010, 32'h10), 0);

        for (int i = 0; i < 150; i++) begin
            logic [2:0]  f  = 3'($urandom);
            logic [31:0] a  = $urandom_range(0, 255);
            logic [31:0] sd = $urandom;
            logic [31:0] rd = $urandom;
            bit          l  = 1'($urandom);
            bit          s  = l ? 1'($urandom) : 1'b1;
            do_access("rand", f, a, sd, rd, l, s, $urandom_range(0, 7),
                      m_sel(f, a), m_ds(f, sd), m_misal(f, a), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv_dmem_port.md
Name: rv_dmem_port

Overview:
- Data-memory access unit between the execute stage and the data bus. It feeds the writeback stage with load data and load/store completion strobes.
- Takes one-cycle load/store request pulses from execute and generates lane-aligned bus cycles with byte selects.
- Waits for the memory ready handshake, with timeout and misalignment detection.
- Load data is returned raw (full 32-bit word); writeback performs lane extraction and sign extension.

Parameters:
- g_timeout, 255: maximum bus wait in cycles after issue before forced completion; legal range 1 to 65535.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- x_load_i  in  1  load request pulse, sampled in IDLE only.
- x_store_i  in  1  store request pulse, sampled in IDLE only.
- x_fun_i  in  3  access size, RISC-V funct3 encoding: B=000, H=001, L=010, BU=100, HU=101.
- x_dm_addr_i  in  32  byte address.
- x_store_value_i  in  32  store data, right-aligned.
- dm_addr_o  out  32  bus address, word-aligned ({addr[31:2],2'b00}).
- dm_data_s_o  out  32  lane-replicated store data.
- dm_data_select_o  out  4  byte enables.
- dm_load_o  out  1  bus read strobe.
- dm_store_o  out  1  bus write strobe.
- dm_ready_i  in  1  bus acknowledge.
- dm_data_i  in  32  bus read data.
- dm_data_l_o  out  32  load word to writeback.
- dm_load_done_o  out  1  load completion strobe.
- dm_store_done_o  out  1  store completion strobe.
- dm_misaligned_o  out  1  pulse: request rejected as misaligned.
- dm_timeout_o  out  1  pulse: access completed by timeout.

Behaviour:
- Reset state:
  - State IDLE.
  - All strobes, dm_data_select_o, dm_misaligned_o and dm_timeout_o are 0.
  - dm_addr_o, dm_data_s_o and dm_data_l_o are 0.
  - Timeout counter is 0.
- Reset mid-operation: returns to IDLE next edge. Bus strobes drop and no done is issued for the aborted access.
- States: IDLE, LOAD, STORE.
- IDLE:
  - x_load_i=1 and access aligned: register address, selects and data; go to LOAD. Request at cycle T gives dm_load_o=1 from T+1.
  - x_store_i=1 and aligned: same, but go to STORE. dm_store_o=1 from T+1.
  - Both requests high: load wins; the store is dropped.
  - dm_ready_i is ignored in IDLE.
- Misaligned access (H/HU with addr[0]=1, or L with addr[1:0]!=0):
  - No bus cycle is issued.
  - In cycle T+1: dm_misaligned_o=1 plus the matching done strobe for one cycle, with dm_data_l_o=0.
- Byte selects:
  - B/BU: one-hot 1<<addr[1:0].
  - H/HU: 0011 if addr[1]=0, else 1100.
  - L: 1111.
  - Any other funct3 is treated as L.
- Store data:
  - B: {4{d[7:0]}}.
  - H: {2{d[15:0]}}.
  - L: d unchanged.
- LOAD/STORE:
  - Strobe and address/select/data held stable until the cycle dm_ready_i=1.
  - In that cycle, done=1 combinationally. For a load, dm_data_l_o=dm_data_i combinationally.
  - Next edge: back to IDLE with strobes 0. dm_data_l_o then holds the captured word until the next load completes.
  - Minimum latency, request to done: 1 cycle. Bus back-to-back is impossible; there is at least 1 IDLE cycle between accesses.
- Timeout:
  - Counter increments each cycle in LOAD/STORE and is cleared on entry.
  - If counter reaches g_timeout with dm_ready_i=0: done=1 and dm_timeout_o=1 for that cycle; load data is 32'h0; then go to IDLE.
  - Ready arriving in the same cycle as expiry counts as a normal completion with timeout_o=0.
- Done strobes are single-cycle and mutually exclusive. Requests arriving outside IDLE are ignored; upstream stalls on writeback's stall request.

Test Plan:
- Zero-wait load: LB, addr=0x1003, dm_ready_i high on first strobe cycle, dm_data_i=0x80FFFFFF -> dm_select=1000 at T+1, dm_addr_o=0x1000, load_done at T+1, dm_data_l_o=0x80FFFFFF held after.
- Waited store: SH, addr=0x2002, data=0x0000BEEF, ready after 3 cycles -> dm_store_o high T+1..T+4, select=1100, dm_data_s_o=0xBEEFBEEF, store_done only at T+4.
- Misaligned: LW at 0x3001 -> no dm_load_o, T+1 misaligned=1 and load_done=1, dm_data_l_o=0.
- Timeout: g_timeout=4, load, ready never -> done and dm_timeout_o at T+5 (counter 0..4), data 0; next request accepted normally.
- Simultaneous x_load_i and x_store_i, then extra pulses while busy -> only the load is issued; busy pulses cause no bus activity.
- rst_i asserted in LOAD at cycle 2 of wait -> strobes 0 next cycle, no done; a subsequent SW at 0x10 completes with select 1111.
